true_dual_port_ram: RTL and testbench
=====================================

TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter ADDR_WIDTH SHALL default to 4; it sets the address width of both ports.
REQ-003 Parameter DATA_WIDTH SHALL default to 16; it sets the word width and SHALL be a multiple of 8.
REQ-004 Parameter DEPTH SHALL default to 16; it sets the number of words and SHALL be at most 2**ADDR_WIDTH.
REQ-005 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_cs, b_cs  in  1  port select
- a_we, b_we  in  1  write enable (qualified by cs)
- a_be, b_be  in  DATA_WIDTH/8  byte enables (qualified by we)
- a_addr, b_addr  in  ADDR_WIDTH  word address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_rdata, b_rdata  out  DATA_WIDTH  read data
- a_rvalid, b_rvalid  out  1  read-data-valid pulse
- init_busy  out  1  memory clear in progress
- collision  out  1  one-cycle pulse on a same-address double write

Function
REQ-006 The FSM SHALL have two states, INIT and RUN; reset SHALL force INIT with an internal clear pointer of 0.
REQ-007 In INIT, the block SHALL write all-zero to word[ptr] each cycle and increment ptr.
- It SHALL go to RUN on the edge that writes word DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-008 init_busy SHALL be 1 in INIT and 0 in RUN; all port requests SHALL be ignored during INIT (no write, no rvalid).
REQ-009 In RUN, each port SHALL treat a request as present when its cs=1 at a rising edge.
- we=0 is a read; we=1 is a write of only the bytes whose be bit is 1.
REQ-010 Read latency SHALL be 1 cycle: for a read sampled at edge k, rdata SHALL be valid and rvalid=1 from edge k until edge k+1.
REQ-011 rvalid SHALL be 0 in any cycle without a read; rdata SHALL hold its last value when no read occurs.
REQ-012 A write SHALL NOT produce rvalid, and ports A and B SHALL operate fully independently except as stated in REQ-013 to REQ-014.
REQ-013 If both ports write the same address in the same edge, bytes enabled on port A SHALL win, bytes enabled only on port B SHALL be written, and collision SHALL pulse 1 for that cycle.
REQ-014 If one port reads an address the other port writes in the same edge, the read SHALL return the pre-write word (read-first), unless REQ-019 applies.
REQ-015 An address >= DEPTH SHALL be out of range:
- writes SHALL be dropped;
- reads SHALL return all-zero with rvalid=1;
- such an access SHALL never raise collision.
REQ-016 If a_be or b_be is all-zero with we=1, it SHALL be a no-op write (no memory change, no collision).

Reset
REQ-017 On rst_n low, regardless of clk, the block SHALL immediately set a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, collision=0, init_busy=1, state INIT, and ptr=0.
REQ-018 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle clear after release; a read in flight SHALL be discarded.

Configuration
REQ-019 Macro TDP_RAM_WRITE_THROUGH_EN:
- When defined, a read colliding with a same-edge write to the same in-range address, from either port, SHALL return the byte-merged post-write word (write-first, including the REQ-013 A-priority merge).
- When undefined, REQ-014 read-first behaviour SHALL apply.
- Latency and every other behaviour SHALL be identical in both builds.

Verification
REQ-020 Reset release followed by 16 idle cycles SHALL show init_busy=1 for exactly 16 cycles; a read of address 5 on each port at the next edge SHALL return 0x0000 with rvalid=1.
REQ-021 A writes 0x1234 to address 3 with be=2'b11; B reads address 3 on the next edge -> b_rdata=0x1234, b_rvalid=1 exactly one cycle later.
REQ-022 Starting from word[7]=0x0000, in one edge A writes 0xAAAA with be=2'b01 and B writes 0xBBBB with be=2'b11 to address 7 -> collision=1 for one cycle, and a later read of address 7 returns 0xBBAA.
REQ-023 With word[2]=0x1111, A writes 0x2222 to address 2 while B reads address 2 in the same edge -> b_rdata=0x1111 without the macro, 0x2222 with TDP_RAM_WRITE_THROUGH_EN.
REQ-024 With DEPTH=12 and ADDR_WIDTH=4, a write of 0xFFFF to address 13 followed by a read of address 13 -> rdata=0x0000 and rvalid=1; words 0 to 11 SHALL be unchanged.
REQ-025 rst_n pulsed low mid-RUN while a read is outstanding -> rvalid=0 immediately, init_busy=1 for DEPTH cycles, and all words SHALL read 0 afterwards.

Source files
------------

// File: rtl/true_dual_port_ram.sv
// true_dual_port_ram
// Two independent read/write ports on one clock, with per-byte write enables.
// After every reset the array is cleared one word per cycle (INIT) before
// requests are accepted (RUN). On a same-word double write, port A wins the
// bytes both ports enable. Out-of-range addresses drop writes and read as zero.
// Optional build macro TDP_RAM_WRITE_THROUGH_EN: a read that meets a same-edge
// write to the same word returns the merged post-write word instead of the
// pre-write word.
module true_dual_port_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_cs,
  input  logic                    b_cs,
  input  logic                    a_we,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    a_rvalid,
  output logic                    b_rvalid,
  output logic                    init_busy,
  output logic                    collision
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   r_a_rdata;
  logic [DATA_WIDTH-1:0]   r_b_rdata;
  logic                    r_a_rvalid;
  logic                    r_b_rvalid;
  logic                    r_init_busy;
  logic                    r_collision;

  logic                    w_run;
  logic                    w_a_in;
  logic                    w_b_in;
  logic                    w_a_wr;
  logic                    w_b_wr;
  logic                    w_a_rd;
  logic                    w_b_rd;
  logic                    w_same;
  logic                    w_col;
  logic [DATA_WIDTH-1:0]   w_a_old;
  logic [DATA_WIDTH-1:0]   w_b_old;
  logic [DATA_WIDTH-1:0]   w_a_mid;
  logic [DATA_WIDTH-1:0]   w_b_mid;
  logic [DATA_WIDTH-1:0]   w_a_post;
  logic [DATA_WIDTH-1:0]   w_b_post;
  logic [DATA_WIDTH-1:0]   w_a_rval;
  logic [DATA_WIDTH-1:0]   w_b_rval;

  // Replace the enabled bytes of old_word with the matching bytes of wr_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wr_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      res[i*8 +: 8] = be[i] ? wr_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

  // Request qualification: only in RUN; writes need an in-range address and
  // at least one enabled byte to count (anything else is a no-op write).
  assign w_run  = (r_state == ST_RUN);
  assign w_a_in = ({1'b0, a_addr} < DEPTH_L);
  assign w_b_in = ({1'b0, b_addr} < DEPTH_L);
  assign w_a_wr = w_run & a_cs & a_we & w_a_in & (|a_be);
  assign w_b_wr = w_run & b_cs & b_we & w_b_in & (|b_be);
  assign w_a_rd = w_run & a_cs & ~a_we;
  assign w_b_rd = w_run & b_cs & ~b_we;
  assign w_same = (a_addr == b_addr);
  assign w_col  = w_a_wr & w_b_wr & w_same;

  // Pre-write words; out-of-range addresses read as zero.
  assign w_a_old = w_a_in ? r_mem[a_addr] : '0;
  assign w_b_old = w_b_in ? r_mem[b_addr] : '0;

  // Post-write word at each port's address: B bytes first, A bytes on top so
  // A wins any byte both ports enable on the same word.
  assign w_a_mid  = (w_b_wr && w_same) ? merge_bytes(w_a_old, b_wdata, b_be) : w_a_old;
  assign w_a_post = w_a_wr ? merge_bytes(w_a_mid, a_wdata, a_be) : w_a_mid;
  assign w_b_mid  = w_b_wr ? merge_bytes(w_b_old, b_wdata, b_be) : w_b_old;
  assign w_b_post = (w_a_wr && w_same) ? merge_bytes(w_b_mid, a_wdata, a_be) : w_b_mid;

`ifdef TDP_RAM_WRITE_THROUGH_EN
  assign w_a_rval = w_a_post;
  assign w_b_rval = w_b_post;
`else
  assign w_a_rval = w_a_old;
  assign w_b_rval = w_b_old;
`endif

  // Storage array: cleared by the INIT sweep, otherwise written by the ports.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= '0;
    end else begin
      if (w_b_wr) r_mem[b_addr] <= w_b_post;
      if (w_a_wr) r_mem[a_addr] <= w_a_post;
    end
  end

  // Control FSM with registered read data, valid, busy and collision flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_init_busy <= 1'b1;
      r_collision <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_a_rvalid  <= 1'b0;
          r_b_rvalid  <= 1'b0;
          r_collision <= 1'b0;
          if (r_ptr == PTR_LAST) begin
            r_state     <= ST_RUN;
            r_ptr       <= '0;
            r_init_busy <= 1'b0;
          end else begin
            r_ptr       <= r_ptr + PTR_ONE;
            r_init_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          r_init_busy <= 1'b0;
          r_collision <= w_col;
          r_a_rvalid  <= w_a_rd;
          r_b_rvalid  <= w_b_rd;
          if (w_a_rd) r_a_rdata <= w_a_rval;
          if (w_b_rd) r_b_rdata <= w_b_rval;
        end
        default: begin
          r_state     <= ST_INIT;
          r_ptr       <= '0;
          r_a_rvalid  <= 1'b0;
          r_b_rvalid  <= 1'b0;
          r_init_busy <= 1'b1;
          r_collision <= 1'b0;
        end
      endcase
    end
  end

  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign init_busy = r_init_busy;
  assign collision = r_collision;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Testbench for true_dual_port_ram (DEPTH=12 so addresses 12..15 are out of range).
module tb_true_dual_port_ram;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 12;
`ifdef TDP_RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          a_cs, b_cs, a_we, b_we;
  logic [1:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, init_busy, collision;

  int nvec;
  int nfail;

  // Reference model state
  logic [DW-1:0] mdl [0:DEPTH-1];
  int            init_left;
  logic [DW-1:0] exp_a_rdata, exp_b_rdata;
  logic          exp_a_rv, exp_b_rv, exp_col, exp_busy;

  true_dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_cs(a_cs), .b_cs(b_cs), .a_we(a_we), .b_we(b_we),
    .a_be(a_be), .b_be(b_be), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .init_busy(init_busy), .collision(collision)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    init_left   = DEPTH;
    exp_a_rdata = '0;
    exp_b_rdata = '0;
    exp_a_rv    = 1'b0;
    exp_b_rv    = 1'b0;
    exp_col     = 1'b0;
    exp_busy    = 1'b1;
  endtask

  // Drive one cycle of requests, advance the model by one edge, sample at +1.
  task automatic cyc(input logic acs, input logic awe, input logic [1:0] abe,
                     input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                     input logic bcs, input logic bwe, input logic [1:0] bbe,
                     input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    bit a_in, b_in, a_w, b_w;
    logic [DW-1:0] a_old, b_old, a_new, b_new;
    a_cs = acs; a_we = awe; a_be = abe; a_addr = aad; a_wdata = awd;
    b_cs = bcs; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
    @(posedge clk);
    if (init_left > 0) begin
      mdl[DEPTH - init_left] = '0;
      init_left = init_left - 1;
      exp_a_rv = 1'b0;
      exp_b_rv = 1'b0;
      exp_col  = 1'b0;
    end else begin
      a_in  = (int'(aad) < DEPTH);
      b_in  = (int'(bad) < DEPTH);
      a_w   = acs && awe && a_in && (abe != 2'b00);
      b_w   = bcs && bwe && b_in && (bbe != 2'b00);
      a_old = a_in ? mdl[aad] : 16'h0000;
      b_old = b_in ? mdl[bad] : 16'h0000;
      exp_col = a_w && b_w && (aad == bad);
      if (b_w) for (int i = 0; i < 2; i++) if (bbe[i]) mdl[bad][i*8 +: 8] = bwd[i*8 +: 8];
      if (a_w) for (int i = 0; i < 2; i++) if (abe[i]) mdl[aad][i*8 +: 8] = awd[i*8 +: 8];
      a_new = a_in ? mdl[aad] : 16'h0000;
      b_new = b_in ? mdl[bad] : 16'h0000;
      exp_a_rv = acs && !awe;
      exp_b_rv = bcs && !bwe;
      if (exp_a_rv) exp_a_rdata = WT ? a_new : a_old;
      if (exp_b_rv) exp_b_rdata = WT ? b_new : b_old;
    end
    exp_busy = (init_left > 0);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  // Count edges until init_busy drops, bounded.
  task automatic wait_init(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (init_busy === 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    #1;
    model_reset();
    nvec++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin nfail++; $display("FAIL rst_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
    nvec++; if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin nfail++; $display("FAIL rst_rdata: got %h %h want 0000 0000", a_rdata, b_rdata); end
    nvec++; if (init_busy !== 1'b1 || collision !== 1'b0) begin nfail++; $display("FAIL rst_flags: got busy=%b col=%b want 1 0", init_busy, collision); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    nvec++; if (n != DEPTH) begin nfail++; $display("FAIL init_len: got %0d want %0d", n, DEPTH); end
    cyc(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
    nvec++; if (a_rdata !== 16'h0000 || a_rvalid !== 1'b1) begin nfail++; $display("FAIL init_rd_a: got %h/%b want 0000/1", a_rdata, a_rvalid); end
    nvec++; if (b_rdata !== 16'h0000 || b_rvalid !== 1'b1) begin nfail++; $display("FAIL init_rd_b: got %h/%b want 0000/1", b_rdata, b_rvalid); end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    nvec++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin nfail++; $display("FAIL wr_no_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
    cyc(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
    nvec++; if (b_rdata !== 16'h1234 || b_rvalid !== 1'b1) begin nfail++; $display("FAIL wr_rd: got %h/%b want 1234/1", b_rdata, b_rvalid); end
    idle();
    nvec++; if (b_rvalid !== 1'b0 || b_rdata !== 16'h1234) begin nfail++; $display("FAIL rd_pulse_hold: got %h/%b want 1234/0", b_rdata, b_rvalid); end
  endtask

  task automatic test_collision();
    cyc(1'b1, 1'b1, 2'b01, 4'd7, 16'hAAAA, 1'b1, 1'b1, 2'b11, 4'd7, 16'hBBBB);
    nvec++; if (collision !== 1'b1) begin nfail++; $display("FAIL col_pulse: got %b want 1", collision); end
    cyc(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b1, 1'b1, 2'b00, 4'd7, 16'h5555);
    nvec++; if (collision !== 1'b0) begin nfail++; $display("FAIL col_one_cycle: got %b want 0", collision); end
    nvec++; if (a_rdata !== 16'hBBAA) begin nfail++; $display("FAIL col_merge: got %h want bbaa", a_rdata); end
  endtask

  task automatic test_read_write_same();
    logic [DW-1:0] want;
    cyc(1'b1, 1'b1, 2'b11, 4'd2, 16'h1111, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    cyc(1'b1, 1'b1, 2'b11, 4'd2, 16'h2222, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0000);
    want = WT ? 16'h2222 : 16'h1111;
    nvec++; if (b_rdata !== want || b_rvalid !== 1'b1) begin nfail++; $display("FAIL rw_same: got %h/%b want %h/1", b_rdata, b_rvalid, want); end
    cyc(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000, 1'b1, 1'b1, 2'b10, 4'd2, 16'h9900);
    want = WT ? 16'h9922 : 16'h2222;
    nvec++; if (a_rdata !== want) begin nfail++; $display("FAIL rw_same_a: got %h want %h", a_rdata, want); end
  endtask

  task automatic test_out_of_range();
    cyc(1'b1, 1'b1, 2'b11, 4'd13, 16'hFFFF, 1'b1, 1'b1, 2'b11, 4'd13, 16'hFFFF);
    nvec++; if (collision !== 1'b0) begin nfail++; $display("FAIL oor_col: got %b want 0", collision); end
    cyc(1'b1, 1'b0, 2'b00, 4'd13, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd15, 16'h0000);
    nvec++; if (a_rdata !== 16'h0000 || a_rvalid !== 1'b1) begin nfail++; $display("FAIL oor_rd_a: got %h/%b want 0000/1", a_rdata, a_rvalid); end
    nvec++; if (b_rdata !== 16'h0000 || b_rvalid !== 1'b1) begin nfail++; $display("FAIL oor_rd_b: got %h/%b want 0000/1", b_rdata, b_rvalid); end
    cyc(1'b1, 1'b1, 2'b00, 4'd4, 16'hDEAD, 1'b1, 1'b1, 2'b00, 4'd4, 16'hBEEF);
    nvec++; if (collision !== 1'b0) begin nfail++; $display("FAIL noop_col: got %b want 0", collision); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 2'b00, AW'(i), 16'h0000, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
      nvec++; if (a_rdata !== mdl[i]) begin nfail++; $display("FAIL oor_keep[%0d]: got %h want %h", i, a_rdata, mdl[i]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          AW'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          AW'($urandom_range(0, 15)), 16'($urandom));
      nvec++; if (a_rvalid !== exp_a_rv || a_rdata !== exp_a_rdata) begin nfail++; $display("FAIL rnd_a[%0d]: got %h/%b want %h/%b", k, a_rdata, a_rvalid, exp_a_rdata, exp_a_rv); end
      nvec++; if (b_rvalid !== exp_b_rv || b_rdata !== exp_b_rdata) begin nfail++; $display("FAIL rnd_b[%0d]: got %h/%b want %h/%b", k, b_rdata, b_rvalid, exp_b_rdata, exp_b_rv); end
      nvec++; if (collision !== exp_col || init_busy !== exp_busy) begin nfail++; $display("FAIL rnd_flags[%0d]: got col=%b busy=%b want %b %b", k, collision, init_busy, exp_col, exp_busy); end
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    cyc(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd8, 16'h0000);
    nvec++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b1) begin nfail++; $display("FAIL pre_rst_rv: got %b%b want 11", a_rvalid, b_rvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    nvec++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || init_busy !== 1'b1) begin nfail++; $display("FAIL mid_rst: got rv=%b%b busy=%b want 00 1", a_rvalid, b_rvalid, init_busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    nvec++; if (n != DEPTH) begin nfail++; $display("FAIL reinit_len: got %0d want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 2'b00, AW'(i), 16'h0000, 1'b1, 1'b0, 2'b00, AW'(DEPTH - 1 - i), 16'h0000);
      nvec++; if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000 || a_rvalid !== 1'b1) begin nfail++; $display("FAIL cleared[%0d]: got %h %h rv=%b want 0000 0000 1", i, a_rdata, b_rdata, a_rvalid); end
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    rst_n = 1'b1;
    a_cs = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_wdata = '0;
    b_cs = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = '0; b_wdata = '0;
    model_reset();
    #2;
    test_reset();
    test_write_read();
    test_collision();
    test_read_write_same();
    test_out_of_range();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
